// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART TX arbiter slice.
//               Holds the arbiter state encoding, the UART byte width and
//               the default gap / timeout lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int GAP_CYCLES_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 200000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first
//               requester at or after the pointer, wrapping around.
// Ports       : i_req   - request vector
//               i_ptr   - search start index
//               o_grant - one-hot winner (zero when nothing requests)
//               o_idx   - binary index of the winner
//               o_valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int IDX_W = $clog2(N_REQ);

  // Candidate index ptr+off folded back into 0..N_REQ-1 (off < N_REQ).
  function automatic logic [IDX_W-1:0] cand_idx(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] c;
    found   = 1'b0;
    c       = '0;
    o_grant = '0;
    o_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = cand_idx(i_ptr, i);
      if (!found && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = c;
      end
    end
    o_valid = found;
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter between
//               N_REQ byte producers, with burst locking, inter-byte gap and
//               a done-wait timeout.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               i_req/i_data/i_last  - per-requester byte, valid, burst end
//               o_ack                - one-cycle capture pulse per requester
//               o_grant              - one-hot current owner
//               o_tx_start/o_tx_data - start pulse and byte to the UART TX
//               i_tx_done            - done pulse from the UART TX
//               o_busy               - arbiter not idle
//               o_timeout            - one-cycle pulse on done-wait expiry
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [UART_DATA_W*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]             i_last,
  output logic [N_REQ-1:0]             o_ack,
  output logic [N_REQ-1:0]             o_grant,
  output logic                         o_tx_start,
  output logic [UART_DATA_W-1:0]       o_tx_data,
  input  logic                         i_tx_done,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int IDX_W   = $clog2(N_REQ);
  // A zero gap still spends one cycle in GAP.
  localparam int GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q,    state_d;
  logic [IDX_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]       owner_q,    owner_d;
  logic                   lock_q,     lock_d;
  logic [N_REQ-1:0]       grant_q,    grant_d;
  logic [N_REQ-1:0]       ack_q,      ack_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q,  tx_data_d;
  logic                   timeout_q,  timeout_d;
  logic [GAP_W-1:0]       gap_cnt_q,  gap_cnt_d;
  logic [TO_W-1:0]        to_cnt_q,   to_cnt_d;

  logic [N_REQ-1:0]       pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [IDX_W-1:0]       owner_inc;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (rr_ptr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_valid (pick_valid)
  );

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pointer position just after the current owner.
  assign owner_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    logic             cap;
    logic [IDX_W-1:0] sel;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    cap        = 1'b0;
    sel        = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A locked burst owner is the only one eligible.
        if (lock_q) begin
          cap = i_req[owner_q];
          sel = owner_q;
        end else begin
          cap = pick_valid;
          sel = pick_idx;
        end
        if (cap) begin
          tx_data_d = i_data[{sel, 3'b000} +: UART_DATA_W];
          ack_d     = onehot(sel);
          grant_d   = onehot(sel);
          owner_d   = sel;
          lock_d    = ~i_last[sel];
          state_d   = ST_START;
        end
      end

      ST_START: begin
        // Start is registered, so it appears in the first WAIT_DONE cycle.
        tx_start_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        // Done takes priority over an expiring timeout.
        if (i_tx_done) begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          grant_d   = '0;
          rr_ptr_d  = owner_inc;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d  = to_cnt_q + TO_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          // Owner keeps the grant only while its burst is still being fed;
          // a dropped request silently aborts the burst.
          if (!(lock_q && i_req[owner_q])) begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = owner_inc;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_ack      = ack_q;
    o_grant    = grant_q;
    o_tx_start = tx_start_q;
    o_tx_data  = tx_data_q;
    o_timeout  = timeout_q;
    o_busy     = (state_q != ST_IDLE);
  end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Requesters are fed
//               from per-requester byte queues; the expected transmit order
//               of randomized traffic comes from a queue-level round-robin
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 16;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   i_req;
  logic [8*N-1:0] i_data;
  logic [N-1:0]   i_last;
  logic           i_tx_done;
  logic [N-1:0]   o_ack;
  logic [N-1:0]   o_grant;
  logic           o_tx_start;
  logic [7:0]     o_tx_data;
  logic           o_busy;
  logic           o_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Per-requester byte queues: {last, data}
  logic [8:0] qmem [N][32];
  int         qh [N];
  int         qt [N];

  // Event logs (cycle = negedge count)
  int cyc = 0;
  int st_k [64];
  int st_d [64];
  int st_c [64];
  int n_st;
  int ack_c [64];
  int ack_g [64];
  int n_ack;
  int n_to;
  int to_c;
  int to_g;
  int done_c;
  int busy_fall_c;
  bit busy_prev;

  bit done_en;
  int done_cnt;
  int lat_fixed;
  bit force_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    int idx, cnt;
    idx = -1;
    cnt = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic push(input int k, input logic [7:0] d, input logic last);
    qmem[k][qt[k]] = {last, d};
    qt[k]++;
  endtask

  task automatic clear_logs();
    n_st = 0; n_ack = 0; n_to = 0; to_c = -1; to_g = -1;
    done_c = -1; busy_fall_c = -1;
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (qh[k] < qt[k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: observe outputs at the negedge, then drive inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_tx_start && n_st < 64) begin
      st_k[n_st] = oh2idx(o_grant);
      st_d[n_st] = int'(o_tx_data);
      st_c[n_st] = cyc;
      n_st++;
    end
    if (|o_ack) begin
      for (int k = 0; k < N; k++) if (o_ack[k] && qh[k] < qt[k]) qh[k]++;
      if (n_ack < 64) begin
        ack_c[n_ack] = cyc;
        ack_g[n_ack] = int'(o_grant);
      end
      n_ack++;
    end
    if (o_timeout) begin
      n_to++;
      to_c = cyc;
      to_g = int'(o_grant);
    end
    if (busy_prev && !o_busy) busy_fall_c = cyc;
    busy_prev = o_busy;

    i_tx_done = 1'b0;
    if (force_done) begin
      i_tx_done  = 1'b1;
      force_done = 1'b0;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        i_tx_done = 1'b1;
        done_c    = cyc;
      end
    end
    if (o_tx_start && done_en)
      done_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));

    for (int k = 0; k < N; k++) begin
      if (qh[k] < qt[k]) begin
        i_req[k]          = 1'b1;
        i_data[8*k +: 8]  = qmem[k][qh[k]][7:0];
        i_last[k]         = qmem[k][qh[k]][8];
      end else begin
        i_req[k]  = 1'b0;
        i_last[k] = 1'b0;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(queues_empty() && !o_busy && done_cnt == 0) && n < budget);
    check("run_within_budget", (n < budget), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = '0; i_last = '0; i_data = '0; i_tx_done = 1'b0;
    done_cnt = 0; force_done = 1'b0;
    for (int k = 0; k < N; k++) begin qh[k] = 0; qt[k] = 0; end
    tick(); tick();
    check("reset_outputs", {o_ack, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout}, 0);
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  int n0;
  int exp_k [64];
  int exp_d [64];
  int n_exp;
  int m_h [N];
  int busy_cnt;

  initial begin
    rst_n = 1'b0; i_req = '0; i_data = '0; i_last = '0; i_tx_done = 1'b0;
    done_en = 1'b1; lat_fixed = 3; done_cnt = 0; force_done = 1'b0;
    busy_prev = 1'b0;
    clear_logs();

    // ---------------- Single byte ----------------
    do_reset();
    push(0, 8'h55, 1'b1);
    n0 = cyc + 1;
    run_until_idle(200);
    check("single_n_start", n_st, 1);
    check("single_ack_cycle", ack_c[0], n0 + 1);
    check("single_ack_grant", ack_g[0], 4'b0001);
    check("single_start_cycle", st_c[0], n0 + 2);
    check("single_start_data", st_d[0], 8'h55);
    check("single_start_owner", st_k[0], 0);
    check("single_busy_fall", busy_fall_c, done_c + GAP + 1);
    check("single_grant_cleared", o_grant, 0);

    // ---------------- Round-robin order ----------------
    do_reset();
    lat_fixed = 0;
    push(0, 8'hA0, 1'b1); push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
    run_until_idle(1000);
    check("rr_n_start", n_st, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_owner_%0d", i), st_k[i], i % 4);
      check($sformatf("rr_data_%0d", i), st_d[i], 8'hA0 + (i % 4));
    end

    // ---------------- Burst lock (pointer now at 1) ----------------
    clear_logs();
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    tick(); tick();
    push(1, 8'hB1, 1'b1);
    run_until_idle(1000);
    check("burst_n_start", n_st, 4);
    check("burst_owner_0", st_k[0], 2); check("burst_data_0", st_d[0], 8'h11);
    check("burst_owner_1", st_k[1], 2); check("burst_data_1", st_d[1], 8'h22);
    check("burst_owner_2", st_k[2], 2); check("burst_data_2", st_d[2], 8'h33);
    check("burst_owner_3", st_k[3], 1); check("burst_data_3", st_d[3], 8'hB1);

    // ---------------- Burst abort (pointer now at 2) ----------------
    clear_logs();
    push(3, 8'h44, 1'b0);
    push(0, 8'h0F, 1'b1);
    push(1, 8'hE1, 1'b1);
    run_until_idle(1000);
    check("abort_n_start", n_st, 3);
    check("abort_owner_0", st_k[0], 3); check("abort_data_0", st_d[0], 8'h44);
    check("abort_owner_1", st_k[1], 0); check("abort_data_1", st_d[1], 8'h0F);
    check("abort_owner_2", st_k[2], 1);
    check("abort_no_timeout", n_to, 0);

    // ---------------- Timeout (pointer now at 2) ----------------
    clear_logs();
    done_en = 1'b0;
    push(2, 8'h77, 1'b1);
    push(3, 8'h78, 1'b1);
    for (int i = 0; i < 300 && n_to == 0; i++) tick();
    check("to_seen_once", n_to, 1);
    check("to_first_owner", st_k[0], 2);
    check("to_cycle", to_c, st_c[0] + TO);
    check("to_grant_cleared", to_g, 0);
    done_en = 1'b1;
    run_until_idle(1000);
    check("to_total_pulses", n_to, 1);
    check("to_n_start", n_st, 2);
    check("to_next_owner", st_k[1], 3);
    check("to_next_data", st_d[1], 8'h78);

    // ---------------- Reset mid-transfer ----------------
    clear_logs();
    done_en = 1'b0;
    push(0, 8'h99, 1'b1);
    for (int i = 0; i < 50 && n_st == 0; i++) tick();
    tick(); tick(); tick();
    check("mid_busy_before_reset", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {o_ack, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout}, 0);
    tick();
    rst_n = 1'b1;
    force_done = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_busy) busy_cnt++;
    end
    check("mid_late_done_ignored", busy_cnt, 0);
    check("mid_no_new_start", n_st, 1);
    done_en = 1'b1;

    // ---------------- Randomized traffic vs queue model ----------------
    for (int r = 0; r < 3; r++) begin
      do_reset();
      lat_fixed = 0;
      for (int k = 0; k < N; k++) begin
        int nb;
        nb = int'($urandom_range(0, 3));
        for (int b = 0; b < nb; b++) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int j = 0; j < len; j++)
            push(k, 8'($urandom), (j == len - 1));
        end
      end
      // Model: serve whole bursts; next burst goes to the first non-empty
      // queue at or after the requester following the last finished burst.
      begin
        int ptr, lk, k;
        ptr = 0; lk = -1; n_exp = 0;
        for (int q = 0; q < N; q++) m_h[q] = qh[q];
        while (1) begin
          k = -1;
          if (lk >= 0) k = lk;
          else
            for (int i = 0; i < N; i++)
              if (k < 0 && m_h[(ptr + i) % N] < qt[(ptr + i) % N]) k = (ptr + i) % N;
          if (k < 0) break;
          exp_k[n_exp] = k;
          exp_d[n_exp] = int'(qmem[k][m_h[k]][7:0]);
          n_exp++;
          if (qmem[k][m_h[k]][8]) begin lk = -1; ptr = (k + 1) % N; end
          else lk = k;
          m_h[k]++;
        end
      end
      run_until_idle(3000);
      check($sformatf("rand%0d_n_start", r), n_st, n_exp);
      for (int i = 0; i < n_exp && i < n_st; i++) begin
        check($sformatf("rand%0d_owner_%0d", r, i), st_k[i], exp_k[i]);
        check($sformatf("rand%0d_data_%0d", r, i), st_d[i], exp_d[i]);
      end
      check($sformatf("rand%0d_no_timeout", r), n_to, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between `N_REQ` byte producers. It accepts one byte at a time from the winning requester and drives the transmitter's start and data inputs. It waits for the transmitter's done pulse, enforces an inter-byte gap, and optionally holds ownership for a multi-byte burst. It sits between the producers and the UART TX datapath, in the same `clk` domain.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 16: idle `clk` cycles after each done before the next start; 0 is allowed.
- `TIMEOUT_CYCLES`, 200000: maximum cycles spent waiting for `i_tx_done`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  N_REQ  per-requester byte valid.
- `i_data`  in  8*N_REQ  byte for requester k is bits [8k+7:8k].
- `i_last`  in  N_REQ  marks the byte presented by requester k as the final byte of its burst.
- `o_ack`  out  N_REQ  one-cycle pulse: byte from requester k captured.
- `o_grant`  out  N_REQ  one-hot current owner; all zero when unowned.
- `o_tx_start`  out  1  one-cycle start pulse to the UART TX.
- `o_tx_data`  out  8  byte to the UART TX.
- `i_tx_done`  in  1  done pulse from the UART TX.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_timeout`  out  1  one-cycle pulse when the done wait expires.

## Operation

- States are IDLE, START, WAIT_DONE and GAP.
- **IDLE**
  - Unlocked: if any `i_req` is high, pick the first requester at or after `rr_ptr`, wrapping around.
  - Locked: serve only the owner.
  - On capture: latch the owner's `i_data` into `o_tx_data`, pulse `o_ack[k]`, set `o_grant` one-hot, and set lock = !`i_last[k]`. Go to START.
- **START**: `o_tx_start`=1 for exactly one cycle, then go to WAIT_DONE and clear the timeout counter.
- **WAIT_DONE**
  - On `i_tx_done`, go to GAP and clear the gap counter.
  - If the counter reaches `TIMEOUT_CYCLES-1` without a done: pulse `o_timeout`, clear lock and grant, advance `rr_ptr` to owner+1, and go to IDLE.
- **GAP**: count `GAP_CYCLES` cycles, then go to IDLE. When `GAP_CYCLES`=0, GAP lasts exactly 1 cycle.
- **Leaving GAP**
  - If lock is set and `i_req[owner]` is high, the owner keeps the grant.
  - If lock is set but `i_req[owner]` is low, the burst is aborted: clear lock and grant, and advance `rr_ptr`. No error is flagged.
  - If unlocked, clear grant and set `rr_ptr` to owner+1, modulo `N_REQ`.
- **Handshake rule**: a requester holds `i_req`, `i_data` and `i_last` stable until it sees its `o_ack`. It may present the next byte in the cycle after the ack.
- Counters are sized with `$clog2` of their bound. The timeout counter saturates and never wraps.

## Timing

- **Reset values**: all outputs 0, state IDLE, `rr_ptr`=0, lock=0.
- **Reset mid-transfer**: everything returns to IDLE immediately. A done pulse arriving after reset is ignored, because it is sampled only in WAIT_DONE.
- **Capture latency**: `i_req` high at edge t in IDLE gives `o_ack` and `o_grant` in cycle t+1, and `o_tx_start` in cycle t+2.
- **`o_tx_data` stability**: held from cycle t+1 until the next capture.
- **Minimum byte period**: 1 (IDLE) + 1 (START) + done latency + max(`GAP_CYCLES`,1) cycles.
- **Done in START cycle**: `i_tx_done` seen in the START cycle is ignored.
- **Done and timeout in the same cycle**: done wins and no timeout is flagged.
- **Requests arriving outside IDLE**: they wait; nothing is captured outside IDLE.

## Structure

- Shared package `uart_pkg` holds:
  - the state enum (IDLE/START/WAIT_DONE/GAP);
  - `UART_DATA_W`=8;
  - the default `GAP_CYCLES` and `TIMEOUT_CYCLES` constants.
- One sub-module, `rr_pick`, is combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and binary index.
  - The FSM, counters and lock stay in the top module.

## Test plan

- **Single byte**
  - Stimulus: `i_req[0]`=1 with `i_data`=0x55, `i_last`=1.
  - Required: `o_ack[0]` at t+1, `o_tx_start` at t+2 with `o_tx_data`=0x55; after done plus 16 gap cycles, `o_busy`=0.
- **Round-robin order**
  - Stimulus: all four requesters continuously request single bytes 0xA0..0xA3.
  - Required: transmit order 0,1,2,3,0; no requester served twice consecutively.
- **Burst lock**
  - Stimulus: requester 2 sends 0x11, 0x22, 0x33 with `i_last` on 0x33, while requester 1 requests throughout.
  - Required: all three bytes from requester 2 go out first, then requester 1.
- **Burst abort**
  - Stimulus: requester 3 sends 0x44 with `i_last`=0, then drops `i_req` during GAP.
  - Required: lock released at GAP exit and requester 0 is granted next; `o_timeout` stays 0.
- **Timeout**
  - Stimulus: `i_tx_done` held low with `TIMEOUT_CYCLES`=50.
  - Required: `o_timeout` pulses exactly once, 50 cycles after WAIT_DONE entry; grant clears; next requester served.
- **Reset mid-transfer**
  - Stimulus: assert `rst_n`=0 during WAIT_DONE, then pulse `i_tx_done` after release.
  - Required: all outputs 0 immediately; the late done produces no GAP entry.
